// File: rtl/urf_pkg.sv
// Shared types and constants for the universal register array access controller.
//   urf_state_e      : controller FSM states
//   URF_READ_LATENCY : cycles from array read_en to valid read_data
package urf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP,
    INIT
  } urf_state_e;

  localparam int unsigned URF_READ_LATENCY = 1;

endpackage

// File: rtl/urf_sweep_counter.sv
// Address counter for the init sweep. Clears to zero, counts up while enabled
// and saturates at DEPTH-1 so a non-power-of-2 depth never wraps past the end.
//   clk, rst  : clock, asynchronous active-low reset
//   i_clr     : load zero (has priority over i_en)
//   i_en      : advance by one
//   o_count   : current index
//   o_last    : o_count == DEPTH-1
module urf_sweep_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_count,
  output logic          o_last
);

  logic [AW-1:0] r_count;
  logic          w_last;

  assign w_last  = (r_count == AW'(DEPTH - 1));
  assign o_count = r_count;
  assign o_last  = w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/urf_access_ctrl.sv
// Initiator-side controller for the universal register array. Takes single
// read/write commands on a valid/ready channel, drives the array pins, returns
// read data on a valid/ready response channel and runs an init fill sweep.
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_*             : command channel (cmd_ready is the only combinational output)
//   rsp_*             : read response channel
//   init_start/value  : request a fill sweep with the given value
//   init_done         : one-cycle pulse after the last sweep write
//   urf_*             : array pins (all registered)
//   cmd_err           : only with URF_ADDR_CHECK_EN; pulses on an out-of-range command
// Optional feature macro: URF_ADDR_CHECK_EN
module urf_access_ctrl
  import urf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [$clog2(DEPTH)-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic                          init_start,
  input  logic [DATA_WIDTH-1:0]         init_value,
  output logic                          init_done,
`ifdef URF_ADDR_CHECK_EN
  output logic                          cmd_err,
`endif
  output logic                          urf_write_en,
  output logic                          urf_read_en,
  output logic [DEPTH-1:0]              urf_write_addr,
  output logic [DEPTH-1:0]              urf_read_addr,
  output logic [DATA_WIDTH-1:0]         urf_write_data,
  input  logic [DATA_WIDTH-1:0]         urf_read_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  urf_state_e            r_state, w_state_d;
  logic                  r_write_en, w_write_en_d;
  logic                  r_read_en, w_read_en_d;
  logic [DEPTH-1:0]      r_write_addr, w_write_addr_d;
  logic [DEPTH-1:0]      r_read_addr, w_read_addr_d;
  logic [DATA_WIDTH-1:0] r_write_data, w_write_data_d;
  logic                  r_rsp_valid, w_rsp_valid_d;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic                  r_init_done, w_init_done_d;
`ifdef URF_ADDR_CHECK_EN
  logic                  r_cmd_err, w_cmd_err_d;
`endif

  logic                  w_cmd_take;
  logic                  w_addr_oor;
  logic                  w_cnt_clr, w_cnt_en, w_cnt_last;
  logic [AW-1:0]         w_count, w_count_nxt;

  urf_sweep_counter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_last  (w_cnt_last)
  );

  // Gated by rst so cmd_ready reads 0 while reset is held, like every other output.
  assign cmd_ready   = rst && (r_state == IDLE) && !init_start;
  assign w_cmd_take  = cmd_valid && cmd_ready;
  assign w_count_nxt = w_count + 1'b1;

`ifdef URF_ADDR_CHECK_EN
  assign w_addr_oor = (32'(cmd_addr) >= DEPTH);
`else
  assign w_addr_oor = 1'b0;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_write_en_d   = 1'b0;
    w_read_en_d    = 1'b0;
    w_write_addr_d = r_write_addr;
    w_read_addr_d  = r_read_addr;
    w_write_data_d = r_write_data;
    w_rsp_valid_d  = 1'b0;
    w_rsp_rdata_d  = r_rsp_rdata;
    w_init_done_d  = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
`ifdef URF_ADDR_CHECK_EN
    w_cmd_err_d    = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (init_start) begin
          // First sweep write (index 0) goes out in the INIT entry cycle.
          w_cnt_clr      = 1'b1;
          w_state_d      = INIT;
          w_write_en_d   = 1'b1;
          w_write_addr_d = '0;
          w_write_data_d = init_value;
        end else if (w_cmd_take) begin
          if (w_addr_oor) begin
`ifdef URF_ADDR_CHECK_EN
            w_cmd_err_d = 1'b1;
`endif
            if (!cmd_write) begin
              w_rsp_rdata_d = '0;
              w_state_d     = RESP;
            end
          end else if (cmd_write) begin
            w_state_d      = WRITE;
            w_write_en_d   = 1'b1;
            w_write_addr_d = {{(DEPTH - AW){1'b0}}, cmd_addr};
            w_write_data_d = cmd_wdata;
          end else begin
            w_state_d     = READ;
            w_read_en_d   = 1'b1;
            w_read_addr_d = {{(DEPTH - AW){1'b0}}, cmd_addr};
          end
        end
      end
      WRITE:   w_state_d = IDLE;
      READ:    w_state_d = CAPTURE;
      CAPTURE: begin
        w_rsp_rdata_d = urf_read_data;
        w_state_d     = RESP;
      end
      RESP: begin
        // rsp_valid follows one cycle after entering RESP and drops on the handshake.
        if (r_rsp_valid && rsp_ready) begin
          w_state_d = IDLE;
        end else begin
          w_rsp_valid_d = 1'b1;
        end
      end
      INIT: begin
        w_cnt_en = 1'b1;
        if (w_cnt_last) begin
          w_state_d     = IDLE;
          w_init_done_d = 1'b1;
        end else begin
          w_write_en_d   = 1'b1;
          w_write_addr_d = {{(DEPTH - AW){1'b0}}, w_count_nxt};
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_write_en   <= 1'b0;
      r_read_en    <= 1'b0;
      r_write_addr <= '0;
      r_read_addr  <= '0;
      r_write_data <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_write_en   <= w_write_en_d;
      r_read_en    <= w_read_en_d;
      r_write_addr <= w_write_addr_d;
      r_read_addr  <= w_read_addr_d;
      r_write_data <= w_write_data_d;
      r_rsp_valid  <= w_rsp_valid_d;
      r_rsp_rdata  <= w_rsp_rdata_d;
      r_init_done  <= w_init_done_d;
    end
  end

`ifdef URF_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err_d;
    end
  end

  assign cmd_err = r_cmd_err;
`endif

  assign urf_write_en   = r_write_en;
  assign urf_read_en    = r_read_en;
  assign urf_write_addr = r_write_addr;
  assign urf_read_addr  = r_read_addr;
  assign urf_write_data = r_write_data;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign init_done      = r_init_done;

endmodule

// File: tb/tb_urf_access_ctrl.sv
// Self-checking bench for urf_access_ctrl (DATA_WIDTH=8, DEPTH=16, default build).
// A behavioural array sits on the urf_* pins; expected read data comes from a
// plain reference memory updated by the bench on every write and sweep it issues.
module tb_urf_access_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_rdata;
  logic            init_start = 1'b0;
  logic [DW-1:0]   init_value = '0;
  logic            init_done;
  logic            urf_write_en;
  logic            urf_read_en;
  logic [DEPTH-1:0] urf_write_addr;
  logic [DEPTH-1:0] urf_read_addr;
  logic [DW-1:0]   urf_write_data;
  logic [DW-1:0]   urf_read_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] arr_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  urf_access_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .init_start     (init_start),
    .init_value     (init_value),
    .init_done      (init_done),
    .urf_write_en   (urf_write_en),
    .urf_read_en    (urf_read_en),
    .urf_write_addr (urf_write_addr),
    .urf_read_addr  (urf_read_addr),
    .urf_write_data (urf_write_data),
    .urf_read_data  (urf_read_data)
  );

  always #5 clk = ~clk;

  // Array with a one-cycle registered read port.
  always @(posedge clk) begin
    if (urf_write_en) arr_mem[urf_write_addr[AW-1:0]] <= urf_write_data;
    if (urf_read_en)  urf_read_data <= arr_mem[urf_read_addr[AW-1:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (urf_write_en || urf_read_en)) check("en_exclusive", 32'(urf_write_en & urf_read_en), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_wen"}, 32'(urf_write_en), 0);
    check({tag, "_ren"}, 32'(urf_read_en), 0);
    check({tag, "_waddr"}, 32'(urf_write_addr), 0);
    check({tag, "_raddr"}, 32'(urf_read_addr), 0);
    check({tag, "_wdata"}, 32'(urf_write_data), 0);
  endtask

  // Full sweep starting from IDLE with init_start already low.
  task automatic run_sweep(input logic [DW-1:0] val);
    check("sweep_rdy_before", 32'(cmd_ready), 1);
    init_start = 1'b1;
    init_value = val;
    #1;
    check("sweep_rdy_blocked", 32'(cmd_ready), 0);
    step();
    init_start = 1'b0;
    init_value = ~val;
    for (int k = 0; k < DEPTH; k++) begin
      check("sweep_wen", 32'(urf_write_en), 1);
      check("sweep_addr", 32'(urf_write_addr), 32'(k));
      check("sweep_data", 32'(urf_write_data), 32'(val));
      check("sweep_done_early", 32'(init_done), 0);
      check("sweep_rdy_busy", 32'(cmd_ready), 0);
      step();
    end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = val;
    check("sweep_done", 32'(init_done), 1);
    check("sweep_wen_off", 32'(urf_write_en), 0);
    step();
    check("sweep_done_pulse", 32'(init_done), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    check("wr_rdy", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    cmd_wdata = ~d;
    check("wr_wen", 32'(urf_write_en), 1);
    check("wr_addr", 32'(urf_write_addr), 32'(a));
    check("wr_data", 32'(urf_write_data), 32'(d));
    check("wr_rdy_busy", 32'(cmd_ready), 0);
    step();
    check("wr_wen_once", 32'(urf_write_en), 0);
    check("wr_rdy_back", 32'(cmd_ready), 1);
    ref_mem[a] = d;
  endtask

  // Read with the response held off for 'hold' cycles once it is valid.
  task automatic do_read(input logic [AW-1:0] a, input int hold);
    logic [DW-1:0] exp;
    int lat;
    exp = ref_mem[a];
    check("rd_rdy", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    rsp_ready = (hold == 0);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    check("rd_ren", 32'(urf_read_en), 1);
    check("rd_addr", 32'(urf_read_addr), 32'(a));
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      check("rd_rdy_wait", 32'(cmd_ready), 0);
      step();
      lat++;
    end
    check("rd_latency", 32'(lat), 3);
    check("rd_data", 32'(rsp_rdata), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      init_start = 1'($urandom_range(0, 1));
      #1;
      check("rd_hold_valid", 32'(rsp_valid), 1);
      check("rd_hold_data", 32'(rsp_rdata), 32'(exp));
      check("rd_hold_rdy", 32'(cmd_ready), 0);
      check("rd_hold_wen", 32'(urf_write_en), 0);
      step();
    end
    init_start = 1'b0;
    rsp_ready  = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd_valid_drop", 32'(rsp_valid), 0);
    check("rd_rdy_back", 32'(cmd_ready), 1);
    check("rd_no_sweep", 32'(urf_write_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, v1, v2;

    // Reset state
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b1;
    step();
    check("post_reset_rdy", 32'(cmd_ready), 1);

    // Sweep fill, then write/read round trip
    run_sweep(8'hA5);
    do_read(4'd9, 0);
    do_write(4'd3, 8'h5C);
    do_read(4'd3, 0);
    do_read(4'd7, 5);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        do_write(a, d);
      end else begin
        do_read(a, int'($urandom_range(0, 3)));
      end
    end
    do_read(4'd15, 0);
    do_read(4'd0, 1);

    // init_start beats a simultaneous command; command goes in after init_done
    v1 = 8'($urandom);
    d  = ~v1;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 4'd10;
    cmd_wdata  = d;
    init_start = 1'b1;
    init_value = v1;
    #1;
    check("prio_rdy", 32'(cmd_ready), 0);
    step();
    init_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("prio_addr", 32'(urf_write_addr), 32'(k));
      check("prio_data", 32'(urf_write_data), 32'(v1));
      check("prio_rdy_busy", 32'(cmd_ready), 0);
      step();
    end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = v1;
    check("prio_done", 32'(init_done), 1);
    check("prio_rdy_after", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    ref_mem[10] = d;
    check("prio_cmd_wen", 32'(urf_write_en), 1);
    check("prio_cmd_addr", 32'(urf_write_addr), 10);
    check("prio_cmd_data", 32'(urf_write_data), 32'(d));
    step();
    do_read(4'd10, 0);
    do_read(4'd11, 0);

    // Reset in the middle of a sweep, while index 6 is on the pins
    v2 = ~v1 ^ 8'h3C;
    init_start = 1'b1;
    init_value = v2;
    step();
    init_start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("abort_addr6", 32'(urf_write_addr), 6);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    for (int k = 0; k < 6; k++) ref_mem[k] = v2;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_done", 32'(init_done), 0);
    end
    #2;
    rst = 1'b1;
    step();
    check("abort_rdy", 32'(cmd_ready), 1);
    check("abort_no_done2", 32'(init_done), 0);
    do_read(4'd5, 0);
    do_read(4'd6, 2);
    do_read(4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
